// File: rtl/bitonic_pkg.sv
// Shared types and schedule helpers for the sequential bitonic sorter.
package bitonic_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int unsigned stages_f(input int unsigned logn);
    return (logn * (logn + 1)) / 2;
  endfunction

  function automatic int unsigned sort_cycles_f(input int unsigned n, input int unsigned logn);
    return (n / 2) * stages_f(logn);
  endfunction

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned LOGN_DEF    = $clog2(N_DEF);
  localparam int unsigned STAGES      = stages_f(LOGN_DEF);
  localparam int unsigned SORT_CYCLES = sort_cycles_f(N_DEF, LOGN_DEF);

  // Lower index of a compare pair: p with a zero spliced in at bit jlog.
  function automatic int unsigned idx_i(input int unsigned p, input int unsigned jlog);
    int unsigned lo_mask;
    lo_mask = (32'd1 << jlog) - 32'd1;
    return ((p >> jlog) << (jlog + 32'd1)) | (p & lo_mask);
  endfunction

endpackage

// File: rtl/bitonic_cx.sv
// Combinational compare-exchange: dir=0 puts the larger word at hi_pos.
module bitonic_cx #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         dir,
  output logic [W-1:0] hi_pos,
  output logic [W-1:0] lo_pos
);

  logic [W-1:0] mx, mn;

  always_comb begin
    mx = (a >= b) ? a : b;
    mn = (a >= b) ? b : a;
    hi_pos = dir ? mn : mx;
    lo_pos = dir ? mx : mn;
  end

endmodule

// File: rtl/bitonic_sort_seq.sv
// Sequential bitonic sorter: serial load, one compare-exchange per cycle, descending drain.
//   state | meaning
//   LOAD  | accepting N words into the buffer
//   SORT  | stepping the k/j/p schedule through the shared compare-exchange
//   DRAIN | presenting buffer words largest first under out_ready
module bitonic_sort_seq
  import bitonic_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy
);

  localparam int LOGN = $clog2(N);
  localparam int IW   = LOGN;
  localparam int IW1  = LOGN + 1;
  localparam int PW   = LOGN - 1;

  state_e         state_q, state_d;
  logic [W-1:0]   mem_q [N];
  logic [IW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [2:0]     kl_q, kl_d, jl_q, jl_d;
  logic [PW-1:0]  p_q, p_d;

  logic [IW1-1:0] i_w;
  logic [IW-1:0]  i_idx, l_idx;
  logic           dir;
  logic [W-1:0]   cx_hi, cx_lo;
  logic           acc, xfer, p_last, last_cx;

  // kl_q holds log2(k)-1, jl_q holds log2(j)
  assign i_w     = IW1'(idx_i(32'(p_q), 32'(jl_q)));
  assign i_idx   = i_w[IW-1:0];
  assign l_idx   = i_idx | (IW'(1) << jl_q);
  assign dir     = |(i_w & (IW1'(1) << (kl_q + 3'd1)));
  assign acc     = (state_q == LOAD) && in_valid;
  assign xfer    = (state_q == DRAIN) && out_ready;
  assign p_last  = (p_q == PW'(N / 2 - 1));
  assign last_cx = (state_q == SORT) && p_last && (jl_q == 3'd0) && (kl_q == 3'(LOGN - 1));

  bitonic_cx #(.W(W)) u_cx (
    .a      (mem_q[i_idx]),
    .b      (mem_q[l_idx]),
    .dir    (dir),
    .hi_pos (cx_hi),
    .lo_pos (cx_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (acc && (wr_q == IW'(N - 1))) state_d = SORT;
      SORT:    if (last_cx) state_d = DRAIN;
      DRAIN:   if (xfer && (rd_q == IW'(N - 1))) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q == SORT);
    out_valid = (state_q == DRAIN);
    out_data  = (state_q == DRAIN) ? mem_q[rd_q] : '0;
  end

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    kl_d = kl_q;
    jl_d = jl_q;
    p_d  = p_q;
    if (acc)  wr_d = wr_q + IW'(1);
    if (xfer) rd_d = rd_q + IW'(1);
    if (state_q == SORT) begin
      p_d = p_q + PW'(1);
      if (p_last) begin
        if (jl_q != 3'd0) begin
          jl_d = jl_q - 3'd1;
        end else if (kl_q == 3'(LOGN - 1)) begin
          kl_d = 3'd0;
          jl_d = 3'd0;
        end else begin
          kl_d = kl_q + 3'd1;
          jl_d = kl_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      kl_q <= '0;
      jl_q <= '0;
      p_q  <= '0;
      for (int n = 0; n < N; n++) mem_q[n] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      kl_q <= kl_d;
      jl_q <= jl_d;
      p_q  <= p_d;
      if (acc) begin
        mem_q[wr_q] <= in_data;
      end else if (state_q == SORT) begin
        mem_q[i_idx] <= cx_hi;
        mem_q[l_idx] <= cx_lo;
      end
    end
  end

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Directed bench for bitonic_sort_seq: hand-sorted vectors, backpressure, ignored input, async reset.
module tb_bitonic_sort_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] vin  [8];
  logic [7:0] vexp [8];

  always #5 clk = ~clk;

  bitonic_sort_seq #(.W(8), .N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Loads vin[start..7]; returns at the negedge after the last accept.
  task automatic load8(input int start, input bit hold_aa);
    int w;
    for (int n = start; n < 8; n++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vin[n];
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("in_ready_load", int'(in_ready), 1);
      @(posedge clk);
    end
    @(negedge clk);
    if (hold_aa) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Counts SORT cycles, then drains against vexp; bp=1 uses out_ready 1,0,0,1 repeating.
  task automatic sort_drain(input bit bp, input bit hold_aa);
    int  busy_n, w, xfer, cyc;
    bit  ordy;
    busy_n    = 0;
    w         = 0;
    out_ready = 1'b0;
    while (!out_valid && w < 100) begin
      if (busy) busy_n++;
      if (hold_aa && w < 3) chk("in_ready_sort", int'(in_ready), 0);
      @(negedge clk);
      w++;
    end
    chk("busy_cycles", busy_n, 24);
    xfer = 0;
    cyc  = 0;
    while (xfer < 8 && cyc < 200) begin
      ordy = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      out_ready = ordy;
      chk("out_valid", int'(out_valid), 1);
      chk("out_data", int'(out_data), int'(vexp[xfer]));
      if (hold_aa) chk("in_ready_drain", int'(in_ready), 0);
      @(posedge clk);
      if (ordy) xfer++;
      cyc++;
      @(negedge clk);
    end
    chk("xfer_count", xfer, 8);
    chk("in_ready_after", int'(in_ready), 1);
    chk("out_valid_after", int'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #23;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic
    vin  = '{8'h03, 8'h11, 8'hF0, 8'h00, 8'h7F, 8'h80, 8'h22, 8'h05};
    vexp = '{8'hF0, 8'h80, 8'h7F, 8'h22, 8'h11, 8'h05, 8'h03, 8'h00};
    load8(0, 1'b0);
    sort_drain(1'b0, 1'b0);

    // duplicates and extremes
    vin  = '{8'h55, 8'hFF, 8'h55, 8'h00, 8'h55, 8'hFF, 8'h55, 8'h00};
    vexp = '{8'hFF, 8'hFF, 8'h55, 8'h55, 8'h55, 8'h55, 8'h00, 8'h00};
    load8(0, 1'b0);
    sort_drain(1'b0, 1'b0);

    // presorted ascending then descending, back to back
    vin  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    vexp = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    load8(0, 1'b0);
    sort_drain(1'b0, 1'b0);
    vin  = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    load8(0, 1'b0);
    sort_drain(1'b0, 1'b0);

    // backpressure
    vin  = '{8'h40, 8'h08, 8'hC8, 8'h19, 8'h64, 8'h02, 8'hFA, 8'h33};
    vexp = '{8'hFA, 8'hC8, 8'h64, 8'h40, 8'h33, 8'h19, 8'h08, 8'h02};
    load8(0, 1'b0);
    sort_drain(1'b1, 1'b0);

    // in_valid held with AA through SORT and DRAIN
    vin  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
    vexp = '{8'hF1, 8'hDE, 8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};
    load8(0, 1'b1);
    sort_drain(1'b0, 1'b1);
    // the held AA lands as word 0 on the first LOAD edge
    vin  = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    vexp = '{8'hAA, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    load8(1, 1'b0);
    sort_drain(1'b0, 1'b0);

    // async reset mid-SORT, between edges
    vin = '{8'h03, 8'h11, 8'hF0, 8'h00, 8'h7F, 8'h80, 8'h22, 8'h05};
    load8(0, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    vin  = '{8'h9C, 8'h01, 8'hFE, 8'h3A, 8'h3A, 8'h77, 8'hC0, 8'h0F};
    vexp = '{8'hFE, 8'hC0, 8'h9C, 8'h77, 8'h3A, 8'h3A, 8'h0F, 8'h01};
    load8(0, 1'b0);
    sort_drain(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
